ram_port_arbiter: RTL
=====================

Name: ram_port_arbiter

Overview:
- Shares the single-port 256x16 program/data RAM between two requesters.
  - Port 0: CPU datapath/controller memory access.
  - Port 1: loader/IO port that preloads programs and inspects results.
- Grants whole cycles to one owner at a time.
- Round-robin fairness with a bounded burst length.
- Drives the RAM's we/addr/d pins and returns registered read data with a valid pulse.

Parameters:
- AW, 8, address width (matches MAR/MemAddr).
- DW, 16, data width (matches ACC/MDR/MemD).
- MAX_BURST, 4, max consecutive accesses by one owner while the other port is requesting; legal range 1..255.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req0  in  1  port 0 access request, level, held until served.
- we0  in  1  port 0 write enable (1=write, 0=read).
- addr0  in  AW  port 0 address.
- wd0  in  DW  port 0 write data.
- gnt0  out  1  port 0 access performed this cycle.
- rvalid0  out  1  port 0 read data valid, 1-cycle pulse.
- rd0  out  DW  port 0 read data.
- req1, we1, addr1, wd1, gnt1, rvalid1, rd1: same as port 0, for port 1.
- MemRW  out  1  RAM write enable (1=write).
- MemAddr  out  AW  RAM address.
- MemD  out  DW  RAM write data.
- MemQ  in  DW  RAM read data, combinational from MemAddr.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (rst=0, async, immediate):
  - state=IDLE, last=1 (port 0 wins the first tie), cnt=0.
  - gnt0/1=0, rvalid0/1=0, rd0/1=0, MemRW=0, MemAddr=0, MemD=0, busy=0.
  - Reset mid-access drops gnt and MemRW at once; no RAM write completes.
- State register holds IDLE, OWN0, OWN1. cnt is 8 bits.
- gntN = (state==OWNN) & reqN, combinational (Mealy).
- An access occurs in any cycle with gntN=1:
  - MemAddr=addrN, MemRW=weN, MemD=wdN.
  - When no grant: MemAddr=0, MemRW=0, MemD=0.
- Read (gntN & !weN): rdN <= MemQ and rvalidN=1 on the next cycle only.
  - rdN holds its value until that port's next read completes.
  - Writes produce no rvalid.
- Transitions on the clock edge:
  - IDLE, both req: go to OWN(~last).
  - IDLE, req0 only: go to OWN0. req1 only: go to OWN1. Neither: stay IDLE.
  - Arbitration latency from IDLE is 1 cycle: a request raised in IDLE is granted the next cycle.
  - OWNn with reqn=0 (no access this cycle):
    - last=n, cnt=0.
    - Next state is OWN(other) if req_other is high, else IDLE.
  - OWNn with an access:
    - If cnt==MAX_BURST-1 and req_other=1: next state OWN(other), cnt=0, last=n. Handover has no dead cycle.
    - Else if cnt==MAX_BURST-1 and req_other=0: cnt=0, stay OWNn. The uncontended owner streams indefinitely.
    - Else: cnt=cnt+1, stay OWNn.
- Simultaneous events:
  - Owner drops req in the same cycle the other raises it: handover on that edge.
  - Address/we/wd changes are sampled only while granted; a requester must hold its inputs stable until it sees gnt.
- Guarantees:
  - At most one gnt high in any cycle.
  - Worst-case wait for a held request is MAX_BURST+1 cycles.
- No internal storage of requests; a requester that drops req before gnt is simply not served.

Test Plan:
1. Reset, then port 1 writes 16'h1234 @8'h10 and 16'hABCD @8'h11 (req1=1, we1=1 for two grants), then reads 8'h10 → gnt1 first asserted 1 cycle after req1; MemRW=1 for two cycles; rvalid1 pulses one cycle after the read grant with rd1=16'h1234.
2. req0=req1=1 from reset, both streaming reads, MAX_BURST=4 → grant pattern 0,0,0,0,1,1,1,1,0,… with no idle cycle between owners; gnt0&gnt1 never both high.
3. MAX_BURST=1, both streaming → strict alternation 0,1,0,1 starting with port 0; each rvalid pulse arrives on the correct port with that port's addressed data.
4. Port 0 alone streams 10 reads (req1=0) → 10 consecutive gnt0 with no break when cnt wraps; busy=1 throughout, returns to 0 one cycle after req0 drops.
5. Port 0 owns and drops req0 on the same edge req1 rises → next cycle gnt1=1 (OWN1), no IDLE cycle in between.
6. Assert rst=0 mid-write while gnt1=1, MemRW=1 → MemRW, gnt1, busy, rvalid* go 0 immediately; after release, RAM contents at that address are unchanged.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between a CPU port (0) and a
// loader/IO port (1), with bounded bursts and registered read-data return.
module ram_port_arbiter #(
  parameter int AW        = 8,
  parameter int DW        = 16,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wd0,
  output logic          gnt0,
  output logic          rvalid0,
  output logic [DW-1:0] rd0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wd1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [DW-1:0] rd1,
  output logic          MemRW,
  output logic [AW-1:0] MemAddr,
  output logic [DW-1:0] MemD,
  input  logic [DW-1:0] MemQ,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  localparam logic [7:0] CNT_LAST = 8'(MAX_BURST - 1);

  state_t     state;
  logic       last;
  logic [7:0] cnt;

  logic   own_id;
  logic   own_req;
  logic   oth_req;
  state_t oth_state;

  // Grants are Mealy so an owner's access happens in the same cycle it asks.
  assign gnt0 = (state == OWN0) & req0;
  assign gnt1 = (state == OWN1) & req1;
  assign busy = (state != IDLE);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    MemRW     = 1'b0;
    MemAddr   = '0;
    MemD      = '0;
    own_id    = (state == OWN1);
    own_req   = own_id ? req1 : req0;
    oth_req   = own_id ? req0 : req1;
    oth_state = own_id ? OWN0 : OWN1;
    if (gnt0) begin
      MemRW   = we0;
      MemAddr = addr0;
      MemD    = wd0;
    end else if (gnt1) begin
      MemRW   = we1;
      MemAddr = addr1;
      MemD    = wd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      last    <= 1'b1;
      cnt     <= '0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rd0     <= '0;
      rd1     <= '0;
    end else begin
      rvalid0 <= gnt0 & ~we0;
      rvalid1 <= gnt1 & ~we1;
      if (gnt0 & ~we0) rd0 <= MemQ;
      if (gnt1 & ~we1) rd1 <= MemQ;

      case (state)
        IDLE: begin
          if (req0 & req1)  state <= last ? OWN0 : OWN1;
          else if (req0)    state <= OWN0;
          else if (req1)    state <= OWN1;
        end
        OWN0, OWN1: begin
          if (!own_req) begin
            last  <= own_id;
            cnt   <= '0;
            state <= oth_req ? oth_state : IDLE;
          end else if (cnt == CNT_LAST) begin
            // Burst limit: yield only if the other port is waiting.
            cnt <= '0;
            if (oth_req) begin
              state <= oth_state;
              last  <= own_id;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
